// File: rtl/led_sequencer.sv
// led_sequencer: Avalon-MM programmable LED pattern player with one-shot/repeat playback and done irq
module led_sequencer #(
  parameter int PATTERN_W = 8,
  parameter int PERIOD_W  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);
  localparam int SW = $clog2(PATTERN_W);
  localparam logic [SW-1:0] LAST = SW'(PATTERN_W - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic rep_q, rep_d, irq_en_q, irq_en_d, done_q, done_d, irq_q, irq_d;
  logic [PERIOD_W-1:0] period_q, period_d, timer_q, timer_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [SW-1:0] step_q, step_d;
  logic wr, ctl_wr, busy, unused_wd;
  assign wr = chipselect & ~write_n;
  assign ctl_wr = wr && address == 2'd0;
  assign busy = state_q == RUN;
  assign out_port = busy & pattern_q[step_q];
  assign irq = irq_q;
  assign unused_wd = ^(writedata >> PERIOD_W);
  always_comb begin
    state_d = state_q;
    rep_d = rep_q;
    irq_en_d = irq_en_q;
    period_d = period_q;
    pattern_d = pattern_q;
    timer_d = timer_q;
    step_d = step_q;
    done_d = done_q;
    irq_d = done_q & irq_en_q;
    if (ctl_wr) begin
      rep_d = writedata[1];
      irq_en_d = writedata[2];
    end
    if (wr && address == 2'd1) period_d = writedata[PERIOD_W-1:0];
    if (wr && address == 2'd2) pattern_d = writedata[PATTERN_W-1:0];
    if (wr && address == 2'd3 && writedata[1]) done_d = 1'b0;
    if (state_q == IDLE) begin
      if (ctl_wr && writedata[0]) begin
        state_d = RUN;
        step_d = '0;
        timer_d = period_q;
      end
    end else if (ctl_wr && !writedata[0]) begin
      state_d = IDLE;
      step_d = '0;
      timer_d = '0;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end else if (step_q != LAST) begin
      step_d = step_q + 1'b1;
      timer_d = period_q;
    end else if (rep_q) begin
      step_d = '0;
      timer_d = period_q;
    end else begin
      state_d = IDLE;
      step_d = '0;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rep_q <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= '0;
      pattern_q <= '0;
      timer_q <= '0;
      step_q <= '0;
      done_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q <= rep_d;
      irq_en_q <= irq_en_d;
      period_q <= period_d;
      pattern_q <= pattern_d;
      timer_q <= timer_d;
      step_q <= step_d;
      done_q <= done_d;
      irq_q <= irq_d;
    end
  end
  always_comb begin
    readdata = address == 2'd0 ? {29'b0, irq_en_q, rep_q, busy} :
               address == 2'd1 ? 32'(period_q) :
               address == 2'd2 ? 32'(pattern_q) :
               {19'b0, 5'(step_q), 6'b0, done_q, busy};
  end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Avalon-MM slave that drives a 1-bit LED output from a programmable bit pattern, one bit per timed step.
- Supports one-shot or repeat playback.
- Raises a level interrupt to the Nios II when a one-shot sequence completes.
- Sits beside the PIO LED port in the interrupt demo system and lets software schedule LED activity without per-step CPU writes.

Parameters:
- PATTERN_W, 8, pattern length in steps; a power of two, 2..32.
- PERIOD_W, 24, width of the step-period register. Step duration is PERIOD+1 clocks.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- address  input  2  register select (word address)
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data; combinational, zero read latency
- out_port  output  1  LED drive
- irq  output  1  level interrupt request

Behaviour:
- Write occurs when chipselect && !write_n. Register map:
  - 0 CONTROL, R/W: [0] run, [1] repeat, [2] irq_en. Other bits read 0.
  - 1 PERIOD, R/W: [PERIOD_W-1:0].
  - 2 PATTERN, R/W: [PATTERN_W-1:0].
  - 3 STATUS: [0] busy (RO), [1] done (write 1 to clear), [12:8] current step index (RO, zero-extended).
- readdata is address-muxed, unused bits are 0, and it is valid in the same cycle.
- Reset values: all registers 0, state IDLE, step=0, timer=0, out_port=0, irq=0, readdata=0 for any address.
- States: IDLE, RUN.
- IDLE:
  - out_port=0, busy=0.
  - A CONTROL write with run=1 loads step=0 and timer=PERIOD (value after any same-cycle write, i.e. current register), then enters RUN next cycle.
  - out_port=PATTERN[0] from the first RUN cycle.
- RUN:
  - busy=1; out_port=PATTERN[step], combinational on the live PATTERN register, so a PATTERN write takes effect next cycle.
  - When timer != 0, timer decrements.
  - When timer==0 and step != PATTERN_W-1: step increments and timer reloads from the current PERIOD. A PERIOD write affects only subsequent reloads.
  - When timer==0 and step==PATTERN_W-1:
    - repeat=1: step wraps to 0 and timer reloads; stays in RUN.
    - repeat=0: enter IDLE, clear CONTROL.run, set done.
  - A CONTROL write with run=0 enters IDLE next cycle. done is not set, step resets to 0, and out_port=0 next cycle.
  - A CONTROL write with run=1 while in RUN does not restart. repeat and irq_en update; playback continues.
  - Changing repeat from 1 to 0 mid-run makes the current pass the last.
- Step timing: each step holds for exactly PERIOD+1 clocks; a full one-shot lasts PATTERN_W*(PERIOD+1) clocks. PERIOD=0 gives one clock per step.
- irq = done & irq_en, registered, so it asserts the cycle after done sets. Clearing irq_en masks irq without clearing done.
- Simultaneous set of done and write-1-to-clear of done in the same cycle: the set wins and done=1.
- Reset asserted mid-RUN: immediate return to reset values; no done, no irq.

Test Plan:
- Reset then read: read all four addresses -> each returns 0; out_port=0, irq=0.
- One-shot: PERIOD=3, PATTERN=0xA5, CONTROL=0x5.
  - out_port follows 1,0,1,0,0,1,0,1 (LSB first), each bit held 4 clocks.
  - After 32 clocks, busy=0 and CONTROL reads 0x4; done=1 and irq=1 one cycle later.
  - STATUS write 0x2 -> irq=0 next cycle.
- Repeat and stop: PERIOD=0, PATTERN=0x01, CONTROL=0x3.
  - out_port pulses 1 clock high in every 8 and step wraps 7->0.
  - After 20 clocks, CONTROL=0x2 -> out_port=0 and busy=0 next cycle; done stays 0.
- Live updates: during a one-shot with PERIOD=9, write PERIOD=1 mid-step 2 -> step 2 finishes its 10 clocks and step 3 onward lasts 2 clocks.
  - A PATTERN write mid-step changes out_port the next cycle.
- Set/clear collision and masking:
  - irq_en=0 run completes -> done=1, irq=0; then setting irq_en=1 -> irq=1.
  - A write-1-to-clear landing on the completion cycle leaves done=1.
- Reset mid-run: assert reset during step 4 of a PERIOD=5 run -> out_port, irq and all registers return to 0 immediately; after release the block stays IDLE.
